// File: rtl/pht_pkg.sv
// Shared types and saturating-counter arithmetic for the pattern history table.
package pht_pkg;

  localparam int unsigned PHT_CTR_W_MAX = 16;

  typedef logic [PHT_CTR_W_MAX-1:0] ctr_t;

  typedef enum logic {
    PHT_INIT  = 1'b0,
    PHT_READY = 1'b1
  } pht_state_e;

  // Unsigned step towards max (taken) or zero (not taken), never wrapping.
  function automatic ctr_t sat_next(input ctr_t ctr, input logic taken, input ctr_t max);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != max) res = ctr + ctr_t'(1);
    end else begin
      if (ctr != '0) res = ctr - ctr_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_sat_ctr_next.sv
// Combinational saturating next-value for one CTR_W-bit counter.
module pht_sat_ctr_next
  import pht_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_next
);

  localparam ctr_t CTR_MAX = ctr_t'({CTR_W{1'b1}});

  assign ctr_next = CTR_W'(sat_next(ctr_t'(ctr), taken, CTR_MAX));

endmodule

// File: rtl/pht_sat_table.sv
// Pattern history table: flop array of saturating counters with a registered
// lookup port, a same-cycle read-modify-write update port and a reset-time init sweep.
//
// Handshake: lookup_valid and upd_valid are single-cycle strobes with no back-pressure;
// they are honoured only while ready is high, and pred_valid pulses for exactly one
// cycle, one cycle after each honoured lookup.
module pht_sat_table
  import pht_pkg::*;
#(
  parameter int IDX_W    = 7,
  parameter int CTR_W    = 2,
  parameter int INIT_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [CTR_W-1:0] pred_ctr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             dbg_state
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);

  pht_state_e state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;

  logic [CTR_W-1:0] mem [DEPTH];

  logic             we;
  logic [IDX_W-1:0] wa;
  logic [CTR_W-1:0] wd;

  logic [CTR_W-1:0] upd_next;
  logic [CTR_W-1:0] lookup_rd;
  logic             lookup_fire;

  pht_sat_ctr_next #(.CTR_W(CTR_W)) u_ctr_next (
    .ctr      (mem[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (upd_next)
  );

  assign ready       = (state == PHT_READY);
  assign dbg_state   = state;
  assign lookup_fire = lookup_valid && ready;

  // Write-first bypass: a lookup colliding with an update sees the updated value.
  assign lookup_rd = (upd_valid && (upd_idx == lookup_idx)) ? upd_next : mem[lookup_idx];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    we        = 1'b0;
    wa        = upd_idx;
    wd        = upd_next;
    case (state)
      PHT_INIT: begin
        we      = 1'b1;
        wa      = ptr;
        wd      = INIT_CTR;
        ptr_nxt = ptr + 1'b1;
        if (ptr == '1) state_nxt = PHT_READY;
      end
      PHT_READY: begin
        we = upd_valid;
      end
      default: state_nxt = PHT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PHT_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Contents are not reset; the init sweep overwrites every entry.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_ctr   <= '0;
    end else begin
      pred_valid <= lookup_fire;
      if (lookup_fire) pred_ctr <= lookup_rd;
    end
  end

  assign pred_taken = pred_ctr[CTR_W-1];

endmodule

// File: tb/tb_pht_sat_table.sv
// Directed bench for pht_sat_table: three parameterisations, scoreboard per instance.
module tb_pht_sat_table;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: IDX_W=3, CTR_W=2, INIT_VAL=1
  logic       a_ready, a_lv, a_pv, a_pt, a_uv, a_ut, a_dbg;
  logic [2:0] a_li, a_ui;
  logic [1:0] a_pc;
  // Instance B: IDX_W=3, CTR_W=3, INIT_VAL=4
  logic       b_ready, b_lv, b_pv, b_pt, b_uv, b_ut, b_dbg;
  logic [2:0] b_li, b_ui;
  logic [2:0] b_pc;
  // Instance C: IDX_W=3, CTR_W=1, INIT_VAL=0
  logic       c_ready, c_lv, c_pv, c_pt, c_uv, c_ut, c_dbg;
  logic [2:0] c_li, c_ui;
  logic [0:0] c_pc;

  logic [1:0] exp_qa[$];
  logic [2:0] exp_qb[$];
  logic [0:0] exp_qc[$];

  pht_sat_table #(.IDX_W(3), .CTR_W(2), .INIT_VAL(1)) dut_a (
    .clk(clk), .rst(rst), .ready(a_ready),
    .lookup_valid(a_lv), .lookup_idx(a_li),
    .pred_valid(a_pv), .pred_taken(a_pt), .pred_ctr(a_pc),
    .upd_valid(a_uv), .upd_idx(a_ui), .upd_taken(a_ut), .dbg_state(a_dbg)
  );

  pht_sat_table #(.IDX_W(3), .CTR_W(3), .INIT_VAL(4)) dut_b (
    .clk(clk), .rst(rst), .ready(b_ready),
    .lookup_valid(b_lv), .lookup_idx(b_li),
    .pred_valid(b_pv), .pred_taken(b_pt), .pred_ctr(b_pc),
    .upd_valid(b_uv), .upd_idx(b_ui), .upd_taken(b_ut), .dbg_state(b_dbg)
  );

  pht_sat_table #(.IDX_W(3), .CTR_W(1), .INIT_VAL(0)) dut_c (
    .clk(clk), .rst(rst), .ready(c_ready),
    .lookup_valid(c_lv), .lookup_idx(c_li),
    .pred_valid(c_pv), .pred_taken(c_pt), .pred_ctr(c_pc),
    .upd_valid(c_uv), .upd_idx(c_ui), .upd_taken(c_ut), .dbg_state(c_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitors ----------------
  logic [1:0] ea;
  logic [2:0] eb;
  logic [0:0] ec;

  always @(negedge clk) begin
    if (a_pv) begin
      if (exp_qa.size() == 0) check("a_unexpected_pred_valid", 1, 0);
      else begin
        ea = exp_qa.pop_front();
        check("a_pred_ctr", a_pc, ea);
        check("a_pred_taken", a_pt, ea[1]);
      end
    end
    if (b_pv) begin
      if (exp_qb.size() == 0) check("b_unexpected_pred_valid", 1, 0);
      else begin
        eb = exp_qb.pop_front();
        check("b_pred_ctr", b_pc, eb);
        check("b_pred_taken", b_pt, eb[2]);
      end
    end
    if (c_pv) begin
      if (exp_qc.size() == 0) check("c_unexpected_pred_valid", 1, 0);
      else begin
        ec = exp_qc.pop_front();
        check("c_pred_ctr", c_pc, ec);
        check("c_pred_taken", c_pt, ec[0]);
      end
    end
  end

  // ---------------- drivers for instance A ----------------
  task automatic a_lookup(input logic [2:0] idx, input logic [1:0] exp);
    a_lv = 1'b1; a_li = idx;
    exp_qa.push_back(exp);
    step();
    a_lv = 1'b0;
  endtask

  task automatic a_update(input logic [2:0] idx, input logic taken);
    a_uv = 1'b1; a_ui = idx; a_ut = taken;
    step();
    a_uv = 1'b0;
  endtask

  // Lookup and update in the same cycle; exp is the value the lookup must return.
  task automatic a_both(input logic [2:0] li, input logic [2:0] ui, input logic taken,
                        input logic [1:0] exp);
    a_lv = 1'b1; a_li = li;
    a_uv = 1'b1; a_ui = ui; a_ut = taken;
    exp_qa.push_back(exp);
    step();
    a_lv = 1'b0; a_uv = 1'b0;
  endtask

  // Called just after the last rst-high edge with rst already low.
  // Optionally fires requests on every instance at sweep cycle req_at.
  task automatic sweep_check(input int req_at);
    for (int i = 0; i < 8; i++) begin
      check("ready_during_init", a_ready, 0);
      check("pred_valid_during_init", a_pv, 0);
      if (i == req_at) begin
        a_lv = 1'b1; a_li = 3'd0; a_uv = 1'b1; a_ui = 3'd0; a_ut = 1'b1;
        b_lv = 1'b1; b_li = 3'd0; b_uv = 1'b1; b_ui = 3'd0; b_ut = 1'b1;
        c_lv = 1'b1; c_li = 3'd0; c_uv = 1'b1; c_ui = 3'd0; c_ut = 1'b1;
      end else begin
        a_lv = 1'b0; a_uv = 1'b0;
        b_lv = 1'b0; b_uv = 1'b0;
        c_lv = 1'b0; c_uv = 1'b0;
      end
      step();
    end
    a_lv = 1'b0; a_uv = 1'b0;
    b_lv = 1'b0; b_uv = 1'b0;
    c_lv = 1'b0; c_uv = 1'b0;
    check("a_ready_after_sweep", a_ready, 1);
    check("a_dbg_state_ready", a_dbg, 1);
    check("b_ready_after_sweep", b_ready, 1);
    check("c_ready_after_sweep", c_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_lv = 0; a_li = 0; a_uv = 0; a_ui = 0; a_ut = 0;
    b_lv = 0; b_li = 0; b_uv = 0; b_ui = 0; b_ut = 0;
    c_lv = 0; c_li = 0; c_uv = 0; c_ui = 0; c_ut = 0;
    step();
    step();
    check("rst_ready", a_ready, 0);
    check("rst_pred_valid", a_pv, 0);
    check("rst_pred_ctr", a_pc, 0);
    check("rst_pred_taken", a_pt, 0);
    rst = 1'b0;

    // Init sweep with ignored requests at sweep cycle 3
    sweep_check(3);
    for (int i = 0; i < 8; i++) a_lookup(3'(i), 2'd1);

    // Saturation up (back-to-back updates), then down with same-cycle lookups
    for (int i = 0; i < 4; i++) a_update(3'd5, 1'b1);
    a_lookup(3'd5, 2'd3);
    a_both(3'd5, 3'd5, 1'b0, 2'd2);
    a_both(3'd5, 3'd5, 1'b0, 2'd1);
    a_both(3'd5, 3'd5, 1'b0, 2'd0);
    a_both(3'd5, 3'd5, 1'b0, 2'd0);
    a_lookup(3'd5, 2'd0);

    // Bypass: different index is independent, same index is write-first
    a_both(3'd2, 3'd3, 1'b1, 2'd1);
    a_both(3'd2, 3'd2, 1'b1, 2'd2);
    a_lookup(3'd3, 2'd2);
    a_lookup(3'd2, 2'd2);

    // idx 6 to 3, then reset mid-sweep and re-init
    a_update(3'd6, 1'b1);
    a_update(3'd6, 1'b1);
    a_lookup(3'd6, 2'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("ready_first_sweep", a_ready, 0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep_check(-1);
    for (int i = 0; i < 8; i++) a_lookup(3'(i), 2'd1);

    // CTR_W=3, INIT_VAL=4: taken updates with same-cycle lookups
    for (int i = 0; i < 5; i++) begin
      b_lv = 1'b1; b_li = 3'd1; b_uv = 1'b1; b_ui = 3'd1; b_ut = 1'b1;
      exp_qb.push_back((i < 3) ? 3'(5 + i) : 3'd7);
      step();
    end
    b_lv = 1'b0; b_uv = 1'b0;

    // CTR_W=1, INIT_VAL=0: last-outcome behaviour
    c_lv = 1'b1; c_li = 3'd2; exp_qc.push_back(1'b0);
    step();
    c_uv = 1'b1; c_ui = 3'd2; c_ut = 1'b1; exp_qc.push_back(1'b1);
    step();
    c_ut = 1'b0; exp_qc.push_back(1'b0);
    step();
    c_uv = 1'b0; exp_qc.push_back(1'b0);
    step();
    c_lv = 1'b0;

    repeat (3) step();
    check("a_queue_drained", exp_qa.size(), 0);
    check("b_queue_drained", exp_qb.size(), 0);
    check("c_queue_drained", exp_qc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pht_sat_table.md
Name: pht_sat_table

Overview:
Parametrised pattern history table for the IF-stage branch predictor. It is the successor to the fixed 2-bit counter update logic.
- Holds 2**IDX_W saturating counters of CTR_W bits.
- Serves one registered lookup per cycle and applies one read-modify-write update per cycle from the EX-stage branch resolution.
- Same-index hazards are bypassed.
- After reset, a sweep FSM initialises every entry before the table reports ready.

Parameters:
IDX_W, 7, table index width; depth = 2**IDX_W entries
CTR_W, 2, saturating counter width (>=1)
INIT_VAL, 1, counter value written to every entry by the init sweep (must be < 2**CTR_W); default = weakly not-taken

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ready  out  1  high once the init sweep is complete
lookup_valid  in  1  lookup request this cycle
lookup_idx  in  IDX_W  entry to read
pred_valid  out  1  registered; lookup result valid this cycle
pred_taken  out  1  registered; MSB of looked-up counter
pred_ctr  out  CTR_W  registered; full looked-up counter value
upd_valid  in  1  update request this cycle
upd_idx  in  IDX_W  entry to update
upd_taken  in  1  resolved branch outcome (1 = taken)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values: ready=0, pred_valid=0, pred_taken=0, pred_ctr=0. FSM state goes to INIT with sweep pointer = 0.
- Table contents are not cleared by rst directly; the INIT sweep overwrites them.
- FSM states:
  - INIT: each cycle writes INIT_VAL to entry [ptr], then ptr++.
  - INIT -> READY on the cycle the write to entry 2**IDX_W-1 completes. ready rises the following cycle, exactly 2**IDX_W cycles after the rst-deassert edge.
  - READY: normal operation. There is no exit from READY except rst.
- rst asserted in any state, including mid-sweep, restarts INIT from ptr=0 on the next edge.
- Requests during INIT: lookup_valid and upd_valid are ignored. pred_valid stays 0 and no update is applied.
- Lookup (READY): latency is 1 cycle.
  - If lookup_valid is high in cycle N, then in cycle N+1: pred_valid=1, pred_ctr=counter[lookup_idx], pred_taken=pred_ctr[CTR_W-1].
  - If lookup_valid is low in cycle N, then pred_valid=0 in N+1. pred_taken and pred_ctr hold their previous values.
- Update (READY): read-modify-write completes in the same cycle; the new value is visible from cycle N+1.
  - upd_taken=1: counter = (counter == 2**CTR_W-1) ? counter : counter+1.
  - upd_taken=0: counter = (counter == 0) ? 0 : counter-1.
  - Arithmetic is unsigned, CTR_W wide, never wraps.
- Simultaneous lookup and update to the same index in cycle N: the lookup returns the post-update value (write-first bypass). Updates to different indices are independent.
- Back-to-back updates to the same index in consecutive cycles: each applies on top of the previous result, with no lost updates.
- CTR_W=1 degenerates to a last-outcome table: taken sets 1, not-taken sets 0.

Decomposition:
- Package pht_pkg:
  - ctr_t typedef (logic [CTR_W-1:0] via parameterised function or localparam).
  - Enum pht_state_e {PHT_INIT, PHT_READY}.
  - Function sat_next(ctr, taken, max) returning the saturated counter.
- One sub-module, pht_sat_ctr_next: combinational saturating next-value logic, parameterised by CTR_W. It is reused by the lookup bypass path and the update path.
- Storage is a flop array in the top module, with one write port muxed between the sweep and the update.

Test Plan:
- Init sweep: assert rst for 1 cycle with IDX_W=3, CTR_W=2, INIT_VAL=1 -> ready=0 for 8 cycles, then 1. A lookup of every index 0..7 returns pred_ctr=1, pred_taken=0, one cycle after each request.
- Saturation up: 4 updates taken on idx 5 from counter 1 -> counter sequence 2,3,3,3; a lookup returns pred_ctr=3, pred_taken=1. Then 4 not-taken updates -> 2,1,0,0, and a lookup returns pred_ctr=0.
- Bypass: counter[2]=1; in the same cycle assert lookup_idx=2 and upd_idx=2 with upd_taken=1 -> next cycle pred_ctr=2, pred_taken=1. With upd_idx=3 instead -> pred_ctr=1.
- Requests during INIT: upd_valid=1 and lookup_valid=1 at sweep cycle 3 -> pred_valid stays 0. After ready, every entry equals INIT_VAL.
- Reset mid-sweep: assert rst at sweep cycle 5 -> ready stays 0 for a further 8 cycles from rst deassert. Before that, idx 6 is updated while ready to counter 3; after re-init, idx 6 reads back INIT_VAL=1.
- Parameter sweep: CTR_W=3, INIT_VAL=4 -> 5 taken updates give 5,6,7,7,7 and pred_taken=1. CTR_W=1, INIT_VAL=0 -> taken then not-taken gives 1 then 0.
